// File: rtl/ws_pe.sv
// Weight-stationary systolic PE: holds one signed weight and computes
// c_out = c_in + a_in * b each enabled cycle, forwarding a_in to the right.
module ws_pe #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter bit SATURATE   = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         b_load,
    input  logic signed [DATA_WIDTH-1:0] b_in,
    input  logic signed [DATA_WIDTH-1:0] a_in,
    output logic signed [DATA_WIDTH-1:0] a_out,
    input  logic signed [ACC_WIDTH-1:0]  c_in,
    output logic signed [ACC_WIDTH-1:0]  c_out
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int EXT_WIDTH  = ACC_WIDTH + 1 - PROD_WIDTH;

    logic signed [DATA_WIDTH-1:0] b_q, b_d;
    logic signed [DATA_WIDTH-1:0] a_out_q, a_out_d;
    logic signed [ACC_WIDTH-1:0]  c_out_q, c_out_d;

    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH:0]    sum_wide;
    logic signed [ACC_WIDTH-1:0]  sum_final;
    logic                         overflow;

    // One guard bit above the accumulator exposes signed overflow of the add.
    assign prod     = a_in * b_q;
    assign sum_wide = {c_in[ACC_WIDTH-1], c_in}
                    + {{EXT_WIDTH{prod[PROD_WIDTH-1]}}, prod};
    assign overflow = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];

    generate
        if (SATURATE) begin : g_sat
            always_comb begin
                sum_final = sum_wide[ACC_WIDTH-1:0];
                if (overflow) begin
                    // Guard bit carries the true sign of the unclamped result.
                    sum_final = sum_wide[ACC_WIDTH]
                              ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                              : {1'b0, {(ACC_WIDTH-1){1'b1}}};
                end
            end
        end else begin : g_wrap
            assign sum_final = sum_wide[ACC_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        b_d     = b_q;
        a_out_d = a_out_q;
        c_out_d = c_out_q;
        if (b_load) begin
            b_d = b_in;
        end
        // The MAC reads b_q, so a same-cycle load only affects later cycles.
        if (enable) begin
            a_out_d = a_in;
            c_out_d = sum_final;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_q     <= '0;
            a_out_q <= '0;
            c_out_q <= '0;
        end else begin
            b_q     <= b_d;
            a_out_q <= a_out_d;
            c_out_q <= c_out_d;
        end
    end

    assign a_out = a_out_q;
    assign c_out = c_out_q;

endmodule

// File: tb/tb_ws_pe.sv
// Directed bench for ws_pe: wrapping and saturating instances share stimulus.
module tb_ws_pe;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              b_load;
    logic signed [7:0]  b_in;
    logic signed [7:0]  a_in;
    logic signed [31:0] c_in;
    logic signed [7:0]  a_out_w, a_out_s;
    logic signed [31:0] c_out_w, c_out_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ws_pe #(.DATA_WIDTH(8), .ACC_WIDTH(32), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .enable(enable), .b_load(b_load), .b_in(b_in),
        .a_in(a_in), .a_out(a_out_w), .c_in(c_in), .c_out(c_out_w)
    );

    ws_pe #(.DATA_WIDTH(8), .ACC_WIDTH(32), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .enable(enable), .b_load(b_load), .b_in(b_in),
        .a_in(a_in), .a_out(a_out_s), .c_in(c_in), .c_out(c_out_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_both(input string tag, input logic signed [31:0] a_exp,
                              input logic signed [31:0] c_exp);
        check({tag, "_a_wrap"}, 32'(a_out_w), a_exp);
        check({tag, "_c_wrap"}, c_out_w, c_exp);
        check({tag, "_a_sat"},  32'(a_out_s), a_exp);
        check({tag, "_c_sat"},  c_out_s, c_exp);
    endtask

    task automatic load_weight(input logic signed [7:0] w);
        b_load = 1'b1; b_in = w; enable = 1'b0;
        step();
        b_load = 1'b0; b_in = 8'sd99;
    endtask

    initial begin
        // Reset with every other input active
        rst = 1'b1; b_load = 1'b1; b_in = 8'sd9; enable = 1'b1;
        a_in = 8'sd3; c_in = 32'sd50;
        step();
        step();
        check_both("reset", 0, 0);

        // Weight was cleared: MAC passes c_in through
        rst = 1'b0; b_load = 1'b0;
        step();
        check_both("post_reset_mac", 3, 50);

        load_weight(8'sd5);
        check_both("load_hold", 3, 50);

        enable = 1'b1; a_in = 8'sd2; c_in = 32'sd10;
        step();
        check_both("mac1", 2, 20);

        a_in = -8'sd4; c_in = 32'sd15;
        step();
        check_both("mac2", -4, -5);

        enable = 1'b0; a_in = 8'sd7; c_in = 32'sd100;
        for (int i = 0; i < 3; i++) begin
            step();
            check_both("hold", -4, -5);
        end

        // Same-cycle load and enable: MAC uses the old weight
        b_load = 1'b1; b_in = 8'sd3; enable = 1'b1; a_in = 8'sd2; c_in = 32'sd0;
        step();
        check_both("collide_old_b", 2, 10);
        b_load = 1'b0;
        step();
        check_both("collide_new_b", 2, 6);

        load_weight(-8'sd128);
        enable = 1'b1; a_in = -8'sd128; c_in = 32'sd0;
        step();
        check_both("ext_neg_neg", -128, 16384);

        load_weight(8'sd127);
        enable = 1'b1; a_in = -8'sd128; c_in = -32'sd1;
        step();
        check_both("ext_pos_neg", -128, -16257);

        load_weight(8'sd1);
        enable = 1'b1; a_in = 8'sd1; c_in = 32'sh7FFF_FFFF;
        step();
        check("ovf_pos_wrap", c_out_w, 32'sh8000_0000);
        check("ovf_pos_sat",  c_out_s, 32'sh7FFF_FFFF);

        a_in = -8'sd1; c_in = 32'sh8000_0000;
        step();
        check("ovf_neg_wrap", c_out_w, 32'sh7FFF_FFFF);
        check("ovf_neg_sat",  c_out_s, 32'sh8000_0000);

        // Reset mid-operation discards weight and results
        rst = 1'b1; enable = 1'b1; a_in = 8'sd5; c_in = 32'sd7;
        step();
        check_both("mid_reset", 0, 0);
        rst = 1'b0;
        step();
        check_both("mid_reset_mac", 5, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
